// File: rtl/bcd2bin_seq_if.sv
// Handshake and data bundle for the sequential BCD-to-binary converter.
interface bcd2bin_seq_if #(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
);
   logic                  start;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  busy;
   logic                  done;
   logic [BIN_W-1:0]      bin_out;
   logic                  err;

   modport master (
      output start, bcd_in,
      input  busy, done, bin_out, err
   );

   modport slave (
      input  start, bcd_in,
      output busy, done, bin_out, err
   );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble:
// one right shift plus per-digit subtract-3 correction per clock.
module bcd2bin_seq #(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   bcd2bin_seq_if.slave  bus
);
   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned SR_W  = BCD_W + BIN_W;
   localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic               load;
   logic [SR_W-1:0]    sr;
   logic [SR_W-1:0]    sr_step;
   logic [CNT_W-1:0]   cnt;
   logic               invalid;
   logic               bad_digit;
   logic               last_step;
   logic [BIN_W-1:0]   bin_q;
   logic               err_q;

   // One iteration: shift the whole register right, then fix up each BCD digit.
   always_comb begin
      sr_step = sr >> 1;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (sr_step[BIN_W + 4*d +: 4] >= 4'd8)
            sr_step[BIN_W + 4*d +: 4] = sr_step[BIN_W + 4*d +: 4] - 4'd3;
      end
   end

   always_comb begin
      bad_digit = 1'b0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (bus.bcd_in[4*d +: 4] > 4'd9)
            bad_digit = 1'b1;
      end
   end

   assign last_step = (cnt == CNT_W'(BIN_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // The edge that ends DONE may accept a new request, giving one
   // conversion every BIN_W+1 cycles.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = CONV;
               load     = 1'b1;
            end
         end
         CONV: begin
            if (last_step)
               state_nx = DONE;
         end
         DONE: begin
            if (bus.start) begin
               state_nx = CONV;
               load     = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         cnt     <= '0;
         invalid <= 1'b0;
         bin_q   <= '0;
         err_q   <= 1'b0;
      end else if (load) begin
         sr      <= {bus.bcd_in, {BIN_W{1'b0}}};
         cnt     <= '0;
         invalid <= bad_digit;
      end else if (state == CONV) begin
         sr  <= sr_step;
         cnt <= cnt + CNT_W'(1);
         if (last_step) begin
            bin_q <= invalid ? '0 : sr_step[BIN_W-1:0];
            err_q <= invalid;
         end
      end
   end

   assign bus.busy    = (state == CONV);
   assign bus.done    = (state == DONE);
   assign bus.bin_out = bin_q;
   assign bus.err     = err_q;
endmodule
